// File: rtl/ws2812_serializer.sv
// WS2812B single-wire NRZ serializer: 24-bit pixel stream in, timed led_sdi waveform out.
// Optional WS2812_UNDERRUN_CNT_EN compiles in the saturating mid-frame underrun counter.
module ws2812_serializer #(
    parameter int N_LEDS       = 8,
    parameter int T0H          = 40,
    parameter int T0L          = 85,
    parameter int T1H          = 80,
    parameter int T1L          = 45,
    parameter int RESET_CYCLES = 6000
) (
    input  logic        clk_100,
    input  logic        glbl_reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        latch_req,
    output logic        led_sdi,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  underrun_cnt
);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam int PW = $clog2(N_LEDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_WAIT, S_LATCH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   phase_cnt, cnt_nxt;
    logic [23:0]     sreg;
    logic [4:0]      bit_idx;
    logic [PW-1:0]   pix_cnt;
    logic            latch_pend, ready_en;
    logic            phase_end, frame_ending, take, shift, underrun;

    function automatic logic [CW-1:0] hi_len(input logic b);
        return b ? CW'(T1H - 1) : CW'(T0H - 1);
    endfunction

    function automatic logic [CW-1:0] lo_len(input logic b);
        return b ? CW'(T1L - 1) : CW'(T0L - 1);
    endfunction

    assign phase_end    = (phase_cnt == '0);
    assign frame_ending = (pix_cnt == PW'(N_LEDS)) || latch_pend || latch_req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = phase_cnt - CW'(1);
        pix_ready = 1'b0;
        shift     = 1'b0;
        underrun  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt   = phase_cnt;
                // a latch request wins over a word offered in the same cycle
                pix_ready = ready_en && !latch_req && !latch_pend;
                if (latch_req || latch_pend) begin
                    state_nxt = S_LATCH;
                    cnt_nxt   = CW'(RESET_CYCLES - 1);
                end else if (pix_valid && pix_ready) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = hi_len(pix_data[23]);
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = lo_len(sreg[23]);
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    if (bit_idx != 5'd0) begin
                        shift     = 1'b1;
                        state_nxt = S_HIGH;
                        cnt_nxt   = hi_len(sreg[22]);
                    end else if (frame_ending) begin
                        state_nxt = S_LATCH;
                        cnt_nxt   = CW'(RESET_CYCLES - 1);
                    end else begin
                        pix_ready = 1'b1;
                        if (pix_valid) begin
                            state_nxt = S_HIGH;
                            cnt_nxt   = hi_len(pix_data[23]);
                        end else begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = CW'(RESET_CYCLES - 1);
                        end
                    end
                end
            end
            S_WAIT: begin
                pix_ready = !(latch_req || latch_pend);
                if (latch_req || latch_pend) begin
                    state_nxt = S_LATCH;
                    cnt_nxt   = CW'(RESET_CYCLES - 1);
                end else if (pix_valid) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = hi_len(pix_data[23]);
                end else if (phase_end) begin
                    // string already latched on its own; restart the frame from scratch
                    state_nxt = S_IDLE;
                    underrun  = 1'b1;
                end
            end
            S_LATCH: begin
                if (phase_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        take = pix_valid && pix_ready;
    end

    assign led_sdi    = (state == S_HIGH);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_LATCH) && phase_end;

    always_ff @(posedge clk_100 or negedge glbl_reset_n) begin
        if (!glbl_reset_n) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            sreg       <= '0;
            bit_idx    <= '0;
            pix_cnt    <= '0;
            latch_pend <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= cnt_nxt;
            ready_en  <= 1'b1;
            if (take) begin
                sreg    <= pix_data;
                bit_idx <= 5'd23;
            end else if (shift) begin
                sreg    <= {sreg[22:0], 1'b0};
                bit_idx <= bit_idx - 5'd1;
            end
            if (frame_done || underrun) pix_cnt <= '0;
            else if (take)              pix_cnt <= pix_cnt + 1'b1;
            if (state_nxt == S_LATCH && state != S_LATCH) latch_pend <= 1'b0;
            else if (latch_req)                           latch_pend <= 1'b1;
        end
    end

`ifdef WS2812_UNDERRUN_CNT_EN
    logic [7:0] urun_q;
    always_ff @(posedge clk_100 or negedge glbl_reset_n) begin
        if (!glbl_reset_n)                   urun_q <= '0;
        else if (underrun && urun_q != 8'hFF) urun_q <= urun_q + 8'd1;
    end
    assign underrun_cnt = urun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_ws2812_serializer.sv
// Randomized bench for ws2812_serializer: decodes led_sdi pulse widths back into words
// and compares against the words offered, plus latch/underrun/reset timing.
module tb_ws2812_serializer;
    localparam int N   = 4;
    localparam int T0H = 1;
    localparam int T0L = 3;
    localparam int T1H = 3;
    localparam int T1L = 2;
    localparam int RC  = 10;
`ifdef WS2812_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_100 = 1'b0;
    logic        glbl_reset_n = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        latch_req = 1'b0;
    logic        pix_ready, led_sdi, busy, frame_done;
    logic [7:0]  underrun_cnt;

    int checks = 0;
    int failures = 0;
    int exp_urun = 0;
    logic [23:0] sent[$];

    // waveform monitor: hq[k] = width of high pulse k, lq[k] = low run just before it
    int   hq[$];
    int   lq[$];
    int   hi_run = 0;
    int   low_run = 0;
    int   fd_cnt = 0;
    logic prev = 1'b0;

    ws2812_serializer #(
        .N_LEDS(N), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .RESET_CYCLES(RC)
    ) dut (
        .clk_100(clk_100), .glbl_reset_n(glbl_reset_n), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .latch_req(latch_req),
        .led_sdi(led_sdi), .busy(busy), .frame_done(frame_done),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk_100 = ~clk_100;

    always @(negedge clk_100) begin
        if (led_sdi) begin
            if (!prev) lq.push_back(low_run);
            low_run <= 0;
            hi_run  <= hi_run + 1;
        end else begin
            if (prev) hq.push_back(hi_run);
            hi_run  <= 0;
            low_run <= low_run + 1;
        end
        prev <= led_sdi;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100);
        #1;
    endtask

    task automatic send(input logic [23:0] w);
        int n;
        pix_data  = w;
        pix_valid = 1'b1;
        for (n = 0; n < 2000; n++) begin
            #1;
            if (pix_ready) break;
            @(negedge clk_100);
        end
        if (n == 2000) begin
            chk("send_timeout", 0, 1);
            pix_valid = 1'b0;
            return;
        end
        tick();
        pix_valid = 1'b0;
        sent.push_back(w);
        chk("latency", int'(led_sdi), 1);
    endtask

    task automatic wait_idle(output int lowlen);
        int n;
        for (n = 0; n < 4000; n++) begin
            tick();
            if (!busy) break;
        end
        if (n == 4000) chk("idle_timeout", 0, 1);
        lowlen = low_run;
    endtask

    task automatic wait_highs(input int target);
        int n;
        for (n = 0; n < 4000; n++) begin
            if (hq.size() >= target) break;
            tick();
        end
        if (n == 4000) chk("highs_timeout", 0, 1);
    endtask

    // expected waveform derived from the offered words: bit widths, inter-bit lows, tail low
    task automatic check_frame(input string tag, input int base, input int tail);
        int nw, bad_hi, bad_lo, k, h;
        logic [23:0] w;
        logic eb, lastb;
        nw = sent.size();
        bad_hi = 0;
        bad_lo = 0;
        lastb = 1'b0;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int b = 0; b < 24; b++) begin
                k  = base + i * 24 + b;
                eb = sent[i][23 - b];
                lastb = eb;
                if (k >= hq.size()) begin
                    bad_hi++;
                    continue;
                end
                h = hq[k];
                if (h != T1H && h != T0H) bad_hi++;
                w = {w[22:0], (h == T1H)};
                if (!(i == nw - 1 && b == 23)) begin
                    if (k + 1 >= lq.size())                  bad_lo++;
                    else if (lq[k + 1] != (eb ? T1L : T0L)) bad_lo++;
                end
            end
            chk({tag, "_word"}, int'(w), int'(sent[i]));
        end
        chk({tag, "_bad_high"}, bad_hi, 0);
        chk({tag, "_bad_low"}, bad_lo, 0);
        chk({tag, "_nbits"}, hq.size() - base, 24 * nw);
        chk({tag, "_tail_low"}, tail, (lastb ? T1L : T0L) + RC + 1);
    endtask

    function automatic int urun_next(input int v);
        return (CNT_EN && v < 255) ? v + 1 : v;
    endfunction

    initial begin
        int base, fd0, tail, n;

        #2;
        chk("rst_led", int'(led_sdi), 0);
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_urun", int'(underrun_cnt), 0);
        tick();
        glbl_reset_n = 1'b1;
        #1;
        chk("ready_before_clk", int'(pix_ready), 0);
        tick();
        chk("ready_after_clk", int'(pix_ready), 1);

        // single known pixel, then WAIT timeout
        sent.delete(); base = hq.size(); fd0 = fd_cnt;
        send(24'hA5F00F);
        wait_idle(tail);
        check_frame("single", base, tail);
        exp_urun = urun_next(exp_urun);
        chk("single_urun", int'(underrun_cnt), exp_urun);
        chk("single_no_fd", fd_cnt - fd0, 0);

        // full frame back-to-back
        sent.delete(); base = hq.size(); fd0 = fd_cnt;
        for (int i = 0; i < N; i++) send(24'($urandom));
        wait_idle(tail);
        check_frame("stream", base, tail);
        chk("stream_fd", fd_cnt - fd0, 1);
        chk("stream_urun", int'(underrun_cnt), exp_urun);

        // short frame then underrun, then a fresh full frame
        sent.delete(); base = hq.size(); fd0 = fd_cnt;
        for (int i = 0; i < 3; i++) send(24'($urandom));
        wait_idle(tail);
        check_frame("short", base, tail);
        exp_urun = urun_next(exp_urun);
        chk("short_urun", int'(underrun_cnt), exp_urun);
        chk("short_no_fd", fd_cnt - fd0, 0);
        sent.delete(); base = hq.size(); fd0 = fd_cnt;
        for (int i = 0; i < N; i++) send(24'($urandom));
        wait_idle(tail);
        check_frame("refill", base, tail);
        chk("refill_fd", fd_cnt - fd0, 1);

        // latch request mid pixel 2
        sent.delete(); base = hq.size(); fd0 = fd_cnt;
        send(24'($urandom));
        send(24'($urandom));
        wait_highs(base + 24 + 13);
        latch_req = 1'b1;
        tick();
        latch_req = 1'b0;
        wait_idle(tail);
        check_frame("early_latch", base, tail);
        chk("early_latch_fd", fd_cnt - fd0, 1);

        // latch request in IDLE beats a simultaneous word
        base = hq.size(); fd0 = fd_cnt;
        pix_data = 24'($urandom); pix_valid = 1'b1; latch_req = 1'b1;
        #1;
        chk("idle_latch_ready", int'(pix_ready), 0);
        tick();
        latch_req = 1'b0; pix_valid = 1'b0;
        chk("idle_latch_busy", int'(busy), 1);
        n = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!busy) break;
            n++;
        end
        chk("idle_latch_len", n, RC);
        chk("idle_latch_fd", fd_cnt - fd0, 1);
        chk("idle_latch_nobits", hq.size() - base, 0);

        // reset during a HIGH phase
        sent.delete();
        send(24'h800000 | 24'($urandom));
        glbl_reset_n = 1'b0;
        #1;
        chk("mid_rst_led", int'(led_sdi), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_urun", int'(underrun_cnt), 0);
        exp_urun = 0;
        tick();
        glbl_reset_n = 1'b1;
        tick();
        chk("mid_rst_ready", int'(pix_ready), 1);
        sent.delete(); base = hq.size();
        send(24'($urandom));
        wait_idle(tail);
        check_frame("post_rst", base, tail);
        exp_urun = urun_next(exp_urun);
        chk("post_rst_urun", int'(underrun_cnt), exp_urun);

        // repeated underruns up to saturation
        for (int i = 1; i <= 260; i++) begin
            sent.delete();
            send(24'($urandom));
            wait_idle(tail);
            exp_urun = urun_next(exp_urun);
            if (i == 253 || i == 260) chk("urun_sat", int'(underrun_cnt), exp_urun);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ws2812_serializer.md
# ws2812_serializer

Converts a stream of 24-bit pixel words into the WS2812B single-wire NRZ waveform for one LED string. Sits directly downstream of the per-string pixel FIFO filled over GPMC, and drives one bit of `led_sdi` at the top level. Frames are delimited by a latch (reset) low period, issued automatically after `N_LEDS` pixels or on request.

## Interface

Parameters:

- `N_LEDS`, 8: pixels per frame (string length), ≥1.
- `T0H`, 40: high cycles for a 0 bit (400 ns at 100 MHz).
- `T0L`, 85: low cycles for a 0 bit.
- `T1H`, 80: high cycles for a 1 bit.
- `T1L`, 45: low cycles for a 1 bit.
- `RESET_CYCLES`, 6000: latch low period (60 µs); must be greater than every bit-phase parameter.

Ports:

- `clk_100` in 1: 100 MHz clock. This is the only clock.
- `glbl_reset_n` in 1: asynchronous, active-low reset.
- `pix_data` in 24: pixel word. Bit 23 is transmitted first.
- `pix_valid` in 1: `pix_data` is valid.
- `pix_ready` out 1: the serializer accepts the word this cycle.
- `latch_req` in 1: one-cycle pulse that ends the current frame early.
- `led_sdi` out 1: serial output line.
- `busy` out 1: high whenever the block is not in IDLE.
- `frame_done` out 1: one-cycle pulse on the last cycle of LATCH.
- `underrun_cnt` out 8: saturating count of mid-frame underruns (see Configuration).

## Operation

- A transfer happens when `pix_valid` and `pix_ready` are both high. The word goes into a 24-bit shift register, `bit_idx` is set to 23, and the pixel counter is incremented.
- States:
  - IDLE: `led_sdi`=0 and `pix_cnt`=0. On a transfer, go to HIGH.
  - HIGH: `led_sdi`=1 for T0H or T1H cycles, chosen by the current bit. Then go to LOW.
  - LOW: `led_sdi`=0 for T0L or T1L cycles. At the end of the phase:
    - If `bit_idx`>0: decrement `bit_idx`, shift, and go to HIGH.
    - Else if the frame is ending: go to LATCH.
    - Else if a transfer occurs on the final LOW cycle: go to HIGH.
    - Else: go to WAIT.
  - WAIT: `led_sdi`=0 and `pix_ready`=1. A transfer goes to HIGH. If the block stays in WAIT for RESET_CYCLES cycles, that is an underrun: go to IDLE, clear `pix_cnt`, and increment `underrun_cnt`. The device has already latched at that point.
  - LATCH: `led_sdi`=0 for RESET_CYCLES cycles. Pulse `frame_done` on the last cycle, clear `pix_cnt`, and go to IDLE.
- The frame is ending when `pix_cnt`==`N_LEDS`, or when the latch-pending flag is set.
- `pix_ready` is high:
  - in IDLE;
  - in WAIT;
  - on the final LOW cycle of bit 0 when the frame is not ending.

  It is low at all other times, including during LATCH.
- `latch_req` sets a sticky latch-pending flag. The flag is cleared on entry to LATCH.
  - If `latch_req` arrives in IDLE, go straight to LATCH. A frame is forced even with zero pixels.
  - If it arrives in WAIT, go to LATCH on the next cycle.
- Phase counter widths are `$clog2(RESET_CYCLES+1)`. Each phase lasts exactly its parameter value in cycles.

## Timing

- Reset values: `led_sdi`=0, `pix_ready`=0, `busy`=0, `frame_done`=0, `underrun_cnt`=0, state=IDLE. `pix_ready` rises on the first clock after reset release.
- Latency: a transfer in cycle n gives `led_sdi`=1 from cycle n+1. Bit 23 starts immediately.
- Back-to-back pixels: if the next word is valid on the final LOW cycle, there are zero extra low cycles between pixels. Each pixel takes exactly the sum of its 24 bit periods.
- If `glbl_reset_n` is asserted mid-bit, `led_sdi` drops to 0 immediately and the in-flight pixel is discarded.
- If `latch_req` and a transfer occur in the same IDLE cycle, `latch_req` wins and the pixel is not accepted (`pix_ready` is forced low that cycle).

## Configuration

- `WS2812_UNDERRUN_CNT_EN` defined: the WAIT timeout counter and the 8-bit `underrun_cnt` are compiled in. The count saturates at 255.
- Not defined: `underrun_cnt` is tied to 0. The WAIT timeout still returns to IDLE and clears `pix_cnt`, but nothing is counted.

## Test plan

- Reset, then present 0xA5F00F with `pix_valid` held: `led_sdi` shows 24 bits MSB first. 1 bits are 80 high / 45 low cycles, 0 bits are 40 high / 85 low. `pix_ready` pulses once.
- Stream `N_LEDS`=8 random words back-to-back:
  - there are no gaps between pixels;
  - LATCH is 6000 low cycles;
  - `frame_done` pulses once;
  - the decoded words match the input.
- Stream 3 pixels, then withhold `pix_valid`:
  - after the third pixel, `led_sdi` stays low for 6000 cycles and the block returns to IDLE;
  - `underrun_cnt`=1 with the macro and 0 without;
  - the next word starts a new frame with `pix_cnt`=1.
- Pulse `latch_req` during pixel 2's bit 10: pixel 2 completes, then LATCH runs and `frame_done` pulses. Pulse `latch_req` in IDLE: a 6000-cycle LATCH occurs with no pixels sent.
- Assert `glbl_reset_n` low during a HIGH phase: `led_sdi`=0 in the same cycle. After release, a new word transmits cleanly from bit 23.
- Underrun 300 times in a row: `underrun_cnt` saturates at 255 (macro defined).
